// File: rtl/lvg_pkg.sv
// Shared definitions for the head/lvg load path.
// Opcodes, loader state encoding and header field positions.
package lvg_pkg;

  localparam logic [1:0] OP_LOAD_INSTR  = 2'b00;
  localparam logic [1:0] OP_LOAD_WEIGHT = 2'b01;
  localparam logic [1:0] OP_RUN         = 2'b10;
  localparam logic [1:0] OP_HALT        = 2'b11;

  localparam int HDR_OP_HI = 15;
  localparam int HDR_OP_LO = 14;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LEN  = 3'd1,
    S_BASE = 3'd2,
    S_DATA = 3'd3,
    S_DROP = 3'd4
  } ld_state_t;

endpackage

// File: rtl/mem_loader.sv
// Stream-driven loader for instruction and weight memories.
// Packets are range-checked whole before any write; also gates core reset.
module mem_loader
  import lvg_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int INSTR_DEPTH  = 256,
  parameter int WEIGHT_DEPTH = 256,
  parameter int IA_W         = $clog2(INSTR_DEPTH),
  parameter int WA_W         = $clog2(WEIGHT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              instr_we,
  output logic [IA_W-1:0]   instr_addr,
  output logic [DATA_W-1:0] instr_wdata,
  output logic              weight_we,
  output logic [WA_W-1:0]   weight_addr,
  output logic [DATA_W-1:0] weight_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              err
);

  localparam logic [DATA_W:0] L_IDEP =
    (DATA_W+1)'(INSTR_DEPTH);
  localparam logic [DATA_W:0] L_WDEP =
    (DATA_W+1)'(WEIGHT_DEPTH);
  localparam logic [DATA_W-1:0] L_ONE =
    DATA_W'(1);

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic              r_ready;
  logic              r_tgt;
  logic [DATA_W-1:0] r_len;
  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_cnt;
  logic              r_core_rst;
  logic              r_err;
  logic              r_iwe;
  logic [IA_W-1:0]   r_iaddr;
  logic [DATA_W-1:0] r_idata;
  logic              r_wwe;
  logic [WA_W-1:0]   r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_acc;
  logic [1:0]        w_op;
  logic [DATA_W:0]   w_end;
  logic [DATA_W:0]   w_depth;
  logic              w_rej;
  logic              w_last;
  logic [DATA_W-1:0] w_addr;

  assign w_acc   = in_valid && r_ready;
  assign w_op    = in_data[HDR_OP_HI:HDR_OP_LO];
  assign w_end   = {1'b0, r_len} + {1'b0, in_data};
  assign w_depth = r_tgt ? L_WDEP : L_IDEP;
  assign w_rej   = (w_end > w_depth) || !r_core_rst;
  assign w_last  = (r_cnt == (r_len - L_ONE));
  assign w_addr  = r_base + r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_HDR: begin
        if (w_acc && !w_op[1]) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_acc) w_state_nxt = S_BASE;
      end
      S_BASE: begin
        if (w_acc) begin
          if (r_len == '0) w_state_nxt = S_HDR;
          else if (w_rej)  w_state_nxt = S_DROP;
          else             w_state_nxt = S_DATA;
        end
      end
      S_DATA, S_DROP: begin
        if (w_acc && w_last) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_tgt      <= 1'b0;
      r_len      <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_core_rst <= 1'b1;
      r_err      <= 1'b0;
      r_iwe      <= 1'b0;
      r_iaddr    <= '0;
      r_idata    <= '0;
      r_wwe      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      // one dead cycle after RUN/HALT lets core_rst settle
      r_ready <= !(r_state == S_HDR && w_acc && w_op[1]);
      r_iwe   <= 1'b0;
      r_wwe   <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          S_HDR: begin
            unique case (1'b1)
              (w_op == OP_RUN): r_core_rst <= 1'b0;
              (w_op == OP_HALT): begin
                r_core_rst <= 1'b1;
                r_err      <= 1'b0;
              end
              default: r_tgt <= w_op[0];
            endcase
          end
          S_LEN: begin
            r_len <= in_data;
            r_cnt <= '0;
          end
          S_BASE: begin
            r_base <= in_data;
            if (w_rej) r_err <= 1'b1;
          end
          S_DATA: begin
            r_cnt <= r_cnt + L_ONE;
            if (r_tgt) begin
              r_wwe   <= 1'b1;
              r_waddr <= w_addr[WA_W-1:0];
              r_wdata <= in_data;
            end else begin
              r_iwe   <= 1'b1;
              r_iaddr <= w_addr[IA_W-1:0];
              r_idata <= in_data;
            end
          end
          S_DROP: r_cnt <= r_cnt + L_ONE;
          default: ;
        endcase
      end
    end
  end

  assign in_ready     = r_ready;
  assign instr_we     = r_iwe;
  assign instr_addr   = r_iaddr;
  assign instr_wdata  = r_idata;
  assign weight_we    = r_wwe;
  assign weight_addr  = r_waddr;
  assign weight_wdata = r_wdata;
  assign core_rst     = r_core_rst;
  assign busy         = (r_state != S_HDR);
  assign err          = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader.
// Write strobes are checked against a queue of expected writes.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        instr_we;
  logic [7:0]  instr_addr;
  logic [15:0] instr_wdata;
  logic        weight_we;
  logic [7:0]  weight_addr;
  logic [15:0] weight_wdata;
  logic        core_rst;
  logic        busy;
  logic        err;

  typedef struct {
    int tgt;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_iwe  = 0;
  int  n_wwe  = 0;
  bit  prev_acc = 1'b0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .instr_we(instr_we),
    .instr_addr(instr_addr),
    .instr_wdata(instr_wdata),
    .weight_we(weight_we),
    .weight_addr(weight_addr),
    .weight_wdata(weight_wdata),
    .core_rst(core_rst),
    .busy(busy),
    .err(err)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_we || weight_we) begin
      check("we_after_acc", int'(prev_acc), 1);
      check("we_excl", int'(instr_we && weight_we), 0);
      if (instr_we) n_iwe++;
      if (weight_we) n_wwe++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_tgt", int'(weight_we), e.tgt);
        if (weight_we) begin
          check("w_addr", int'(weight_addr), e.addr);
          check("w_data", int'(weight_wdata), e.data);
        end else begin
          check("i_addr", int'(instr_addr), e.addr);
          check("i_data", int'(instr_wdata), e.data);
        end
      end
    end
    prev_acc = in_valid && in_ready && !rst;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      cyc(1);
      t++;
    end
    if (t >= 50) check("send_timeout", 1, 0);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic expw(input int tgt, input int a, input int d);
    wr_t e;
    e.tgt  = tgt;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ready"}, int'(in_ready), 0);
    check({tag, "_we"}, int'(instr_we | weight_we), 0);
    check({tag, "_iaddr"}, int'(instr_addr), 0);
    check({tag, "_idata"}, int'(instr_wdata), 0);
    check({tag, "_waddr"}, int'(weight_addr), 0);
    check({tag, "_wdata"}, int'(weight_wdata), 0);
    check({tag, "_crst"}, int'(core_rst), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1 [9];
    int ni, nw;
    t1 = '{16'h0001, 16'h1002, 16'h2003, 16'h0008, 16'h0004,
           16'h0001, 16'h3002, 16'h4003, 16'h0006};
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    cyc(2);
    chk_reset("rst");
    rst = 1'b0;
    cyc(1);
    check("ready_after_rst", int'(in_ready), 1);

    // instruction load
    for (int k = 0; k < 9; k++) expw(0, k, int'(t1[k]));
    send(16'h0000);
    check("busy_in_pkt", int'(busy), 1);
    send(16'h0009);
    send(16'h0000);
    for (int k = 0; k < 9; k++) send(t1[k]);
    cyc(2);
    check("t1_iwe", n_iwe, 9);
    check("t1_wwe", n_wwe, 0);
    check("t1_err", int'(err), 0);
    check("t1_busy", int'(busy), 0);

    // weight load with gaps
    for (int k = 0; k < 80; k++) expw(1, k, 16'h0100 + k * 3);
    send(16'h4000);
    send(16'h0050);
    send(16'h0000);
    for (int k = 0; k < 80; k++) begin
      send(16'(16'h0100 + k * 3));
      cyc($urandom_range(0, 2));
    end
    cyc(2);
    check("t2_wwe", n_wwe, 80);
    check("t2_iwe", n_iwe, 9);
    check("t2_err", int'(err), 0);

    // out of range: 250 + 10 > 256
    ni = n_iwe;
    nw = n_wwe;
    send(16'h0000);
    send(16'h000A);
    send(16'h00FA);
    for (int k = 0; k < 10; k++) send(16'h5550 + 16'(k));
    cyc(2);
    check("t3_err", int'(err), 1);
    check("t3_nowr", n_iwe + n_wwe, ni + nw);
    expw(0, 16'h10, 16'hABCD);
    send(16'h0000);
    send(16'h0001);
    send(16'h0010);
    send(16'hABCD);
    cyc(2);
    check("t3_next", n_iwe, ni + 1);
    check("t3_err_sticky", int'(err), 1);

    // boundary: 255 + 1 == 256 is accepted
    expw(1, 255, 16'h7777);
    send(16'h4000);
    send(16'h0001);
    send(16'h00FF);
    send(16'h7777);
    cyc(2);
    check("edge_wwe", n_wwe, nw + 1);

    // halt clears err, then run
    send(16'hC000);
    check("halt_err", int'(err), 0);
    check("halt_crst", int'(core_rst), 1);
    check("halt_ready", int'(in_ready), 0);
    cyc(1);
    send(16'h8000);
    check("run_crst", int'(core_rst), 0);
    check("run_ready", int'(in_ready), 0);
    cyc(1);
    check("run_ready2", int'(in_ready), 1);
    ni = n_iwe;
    send(16'h0000);
    send(16'h0002);
    send(16'h0000);
    send(16'h1111);
    send(16'h2222);
    cyc(2);
    check("run_load_err", int'(err), 1);
    check("run_load_nowr", n_iwe, ni);
    check("run_busy", int'(busy), 0);
    send(16'h8000);
    check("run_again", int'(core_rst), 0);
    cyc(1);
    send(16'hC000);
    check("halt2_crst", int'(core_rst), 1);
    check("halt2_err", int'(err), 0);
    cyc(1);

    // reset mid-packet
    ni = n_iwe;
    for (int k = 0; k < 3; k++) expw(0, 16'h20 + k, 16'h0A00 + k);
    send(16'h0000);
    send(16'h0009);
    send(16'h0020);
    for (int k = 0; k < 3; k++) send(16'h0A00 + 16'(k));
    rst = 1'b1;
    cyc(1);
    chk_reset("mid");
    rst = 1'b0;
    cyc(4);
    check("mid_nowr", n_iwe, ni + 3);
    for (int k = 0; k < 2; k++) expw(1, 16'h30 + k, 16'hBEE0 + k);
    send(16'h4000);
    send(16'h0002);
    send(16'h0030);
    send(16'hBEE0);
    send(16'hBEE1);
    cyc(2);
    check("fresh_wwe", n_wwe, nw + 3);

    // zero length
    nw = n_wwe;
    send(16'h4000);
    send(16'h0000);
    send(16'h0005);
    check("zl_busy", int'(busy), 0);
    check("zl_err", int'(err), 0);
    expw(1, 5, 16'h1234);
    send(16'h4000);
    send(16'h0001);
    send(16'h0005);
    send(16'h1234);
    cyc(2);
    check("zl_next", n_wwe, nw + 1);
    check("q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Host-side writer that fills the instruction memory and weight memory read by the head/lvg datapath, then gates the core's reset.
- Accepts a 16-bit valid/ready word stream carrying packets: LOAD_INSTR, LOAD_WEIGHT, RUN and HALT.
- Issues registered single-word write strobes to the two memories.
- Replaces direct memory pokes and $readmemh with a synthesizable load path. Sits between the host link and head.

Parameters:
- DATA_W, 16, width of stream words and memory words.
- INSTR_DEPTH, 256, number of instruction memory words.
- WEIGHT_DEPTH, 256, number of weight memory words.
- IA_W, $clog2(INSTR_DEPTH), instruction address width.
- WA_W, $clog2(WEIGHT_DEPTH), weight address width.

Ports:
- clk  in  1  clock; everything rises on posedge clk.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  DATA_W  stream word.
- instr_we  out  1  instruction memory write strobe.
- instr_addr  out  IA_W  instruction write address.
- instr_wdata  out  DATA_W  instruction write data.
- weight_we  out  1  weight memory write strobe.
- weight_addr  out  WA_W  weight write address.
- weight_wdata  out  DATA_W  weight write data.
- core_rst  out  1  reset to head core; 1 means held.
- busy  out  1  loader is inside a packet (not in S_HDR).
- err  out  1  sticky error flag; cleared only by rst or HALT.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM to S_HDR.
  - in_ready=0; all we/addr/wdata=0.
  - core_rst=1, busy=0, err=0, counters=0.
  - Reset mid-packet abandons the packet; no further writes occur.
- in_ready is registered. It is 1 in every cycle after reset except the single cycle following an accepted RUN or HALT header. A beat is accepted when in_valid && in_ready.
- Header word fields:
  - in_data[15:14] is the opcode: 00 LOAD_INSTR, 01 LOAD_WEIGHT, 10 RUN, 11 HALT.
  - in_data[13:0] is ignored.
- FSM states: S_HDR, S_LEN, S_BASE, S_DATA, S_DROP.
- S_HDR:
  - LOAD_x latches the target and goes to S_LEN.
  - RUN: core_rst<=0 next cycle; stay in S_HDR.
  - HALT: core_rst<=1 and err<=0 next cycle; stay in S_HDR.
- S_LEN: latch len=in_data (unsigned word count), go to S_BASE.
- S_BASE: latch base=in_data, then evaluate the packet:
  - The packet is rejected when either holds:
    - base+len > target depth, computed at DATA_W+1 bits so there is no wrap.
    - core_rst==0, i.e. writing while the core runs.
  - Rejected with len>0: set err, go to S_DROP.
  - Rejected with len==0: set err, go to S_HDR.
  - Accepted with len==0: go to S_HDR, no writes.
  - Otherwise: go to S_DATA.
- S_DATA:
  - Each accepted beat k (0..len-1) produces exactly one we pulse on the cycle after acceptance, with addr=base+k and wdata=that beat.
  - After beat len-1, return to S_HDR.
  - Idle in_valid cycles insert gaps and never produce spurious strobes.
- S_DROP: consume len beats with no strobes, then return to S_HDR.
- Whole-packet range check: a rejected packet never writes partially.
- instr_we and weight_we are never high together. Each pulse is one cycle per beat, so back-to-back beats give back-to-back pulses.
- addr/wdata hold their last value when we=0.
- busy=1 in S_LEN, S_BASE, S_DATA and S_DROP.
- A RUN received while already running is harmless; so is a HALT while halted.

Decomposition:
- Shared package lvg_pkg holds:
  - opcode localparams OP_LOAD_INSTR=2'b00, OP_LOAD_WEIGHT=2'b01, OP_RUN=2'b10, OP_HALT=2'b11;
  - the state encoding typedef;
  - the header field bit positions.
- A single flat module is natural. No sub-module is required. The write port logic is duplicated per target, not abstracted.

Test Plan:
- Instruction load:
  - Stimulus: reset, then stream 0000,0009,0000 followed by 0001,1002,2003,0008,0004,0001,3002,4003,0006.
  - Expect: 9 instr_we pulses, addr 0..8, matching data; weight_we stays 0; err=0.
- Weight load with stalls:
  - Stimulus: 4000,0050,0000 then 80 words, with in_valid low for random gaps.
  - Expect: exactly 80 weight_we pulses, addr 0..79, data in order, each one cycle after its accept.
- Out-of-range:
  - Stimulus: 0000,000A,00FA (250+10>256) then 10 words, then a valid 1-word instr load to addr 0x10.
  - Expect: err=1; no strobes for the bad packet; the next packet writes addr 0x10 normally.
- Run/halt:
  - Stimulus: 8000.
  - Expect: core_rst falls next cycle; in_ready is low one cycle.
  - Then stimulus: a LOAD_INSTR of 2 words.
  - Expect: err=1, no writes.
  - Then stimulus: C000.
  - Expect: core_rst=1, err=0.
- Reset mid-packet:
  - Stimulus: assert rst after the 3rd payload beat of a 9-word load.
  - Expect: all outputs at reset values next cycle; no further writes.
  - Then stimulus: a fresh packet.
  - Expect: it loads correctly.
- Zero length:
  - Stimulus: 4000,0000,0005.
  - Expect: no strobes, err=0, busy drops next cycle, the next header is accepted.
